// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the sync_fifo_prog codebase slice.
package fifo_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

  // Occupancy and thresholds need one extra bit so that DEPTH itself is representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 32'sd1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus for sync_fifo_prog: master drives requests and
// thresholds, slave (the FIFO) returns data, flags and occupancy.
interface sync_fifo_prog_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int CW = cnt_width(ADDR_WIDTH);

  logic                  wrreq;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rdreq;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_full;
  logic                  rd_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         afull_thresh;
  logic [CW-1:0]         aempty_thresh;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output wrreq, data_in, rdreq, afull_thresh, aempty_thresh, clr_err,
    input  data_out, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wrreq, data_in, rdreq, afull_thresh, aempty_thresh, clr_err,
    output data_out, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock simple dual-port storage with a registered read port whose
// output register always clears on reset; the array clears only if MEM_INIT_ZERO.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int MEM_INIT_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  generate
    if (MEM_INIT_ZERO != 0) begin : g_mem_rst
      // Storage array write port, cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_WIDTH{1'b0}};
          end
        end else if (wr_en_i) begin
          mem_q[wr_addr_i] <= wr_data_i;
        end
      end
    end else begin : g_mem_norst
      // Storage array write port, contents survive reset.
      always_ff @(posedge clk) begin
        if (wr_en_i) begin
          mem_q[wr_addr_i] <= wr_data_i;
        end
      end
    end
  endgenerate

  // Registered read port (read-first on an address collision).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= {DATA_WIDTH{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky
// errors. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int MEM_INIT_ZERO = 1
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_prog_if.slave bus
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_full_s, rd_empty_s, wr_en_s, rd_en_s;
  logic                  ram_rd_en_s;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_s;
  logic [DATA_WIDTH-1:0] ram_rd_data_s;

  assign wr_full_s  = (count_q == DEPTH_C);
  assign rd_empty_s = (count_q == {CW{1'b0}});
  assign wr_en_s    = bus.wrreq & ~wr_full_s;
  assign rd_en_s    = bus.rdreq & ~rd_empty_s;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the same cycle as clr_err keeps the flag set.
    overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wrreq & wr_full_s);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.rdreq & rd_empty_s);
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MEM_INIT_ZERO(MEM_INIT_ZERO)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_en_s),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(bus.data_in),
    .rd_en_i  (ram_rd_en_s),
    .rd_addr_i(ram_rd_addr_s),
    .rd_data_o(ram_rd_data_s)
  );

`ifdef SYNC_FIFO_FWFT_EN
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q;

  // The RAM continuously prefetches the next head; a write landing on that
  // head slot this cycle is forwarded because the RAM read is read-first.
  assign ram_rd_en_s   = 1'b1;
  assign ram_rd_addr_s = rd_ptr_d;
  assign byp_d         = wr_en_s & (wr_ptr_q == rd_ptr_d);

  // Write-to-head forwarding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      byp_q      <= byp_d;
      byp_data_q <= bus.data_in;
    end
  end

  assign bus.data_out = byp_q ? byp_data_q : ram_rd_data_s;
  assign bus.rd_valid = ~rd_empty_s;
`else
  logic rd_valid_q;

  assign ram_rd_en_s   = rd_en_s;
  assign ram_rd_addr_s = rd_ptr_q;

  // Read-valid strobe, one cycle after an accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_s;
    end
  end

  assign bus.data_out = ram_rd_data_s;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.wr_full      = wr_full_s;
  assign bus.rd_empty     = rd_empty_s;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= bus.afull_thresh);
  assign bus.almost_empty = (count_q <= bus.aempty_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog (DATA_WIDTH=8, ADDR_WIDTH=4); covers the
// FWFT variant when SYNC_FIFO_FWFT_EN is defined.
module tb_sync_fifo_prog;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] sb_q [$];

  sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MEM_INIT_ZERO(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wrreq   = 1'b0;
    bus.rdreq   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  // Monitor: pop the scoreboard whenever the FIFO presents a read word.
`ifdef SYNC_FIFO_FWFT_EN
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1 && bus.rdreq === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pop", 32'(bus.data_out), 32'hFFFF_FFFF);
      end else begin
        chk("rd_data", 32'(bus.data_out), 32'(sb_q.pop_front()));
      end
    end
  end
`else
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'(bus.data_out), 32'hFFFF_FFFF);
      end else begin
        chk("rd_data", 32'(bus.data_out), 32'(sb_q.pop_front()));
      end
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    bus.data_in       = 8'h00;
    bus.afull_thresh  = 5'd12;
    bus.aempty_thresh = 5'd3;
    step();
    step();
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_empty",    32'(bus.rd_empty), 32'd1);
    chk("rst_full",     32'(bus.wr_full),  32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_underflow",32'(bus.underflow),32'd0);
    chk("rst_aempty",   32'(bus.almost_empty), 32'd1);
    chk("rst_afull",    32'(bus.almost_full),  32'd0);
    rst = 1'b0;

`ifdef SYNC_FIFO_FWFT_EN
    bus.wrreq = 1'b1; bus.data_in = 8'hA5;
    step();
    bus.wrreq = 1'b0;
    chk("fwft_empty",    32'(bus.rd_empty), 32'd0);
    chk("fwft_valid",    32'(bus.rd_valid), 32'd1);
    chk("fwft_head",     32'(bus.data_out), 32'hA5);
    chk("fwft_count",    32'(bus.count),    32'd1);
    bus.rdreq = 1'b1; sb_q.push_back(8'hA5);
    step();
    bus.rdreq = 1'b0;
    chk("fwft_pop_empty", 32'(bus.rd_empty), 32'd1);
    chk("fwft_pop_count", 32'(bus.count),    32'd0);
    chk("fwft_pop_valid", 32'(bus.rd_valid), 32'd0);
    bus.wrreq = 1'b1; bus.data_in = 8'hB1;
    step();
    bus.data_in = 8'hB2;
    step();
    bus.wrreq = 1'b0;
    chk("fwft_head2",  32'(bus.data_out), 32'hB1);
    chk("fwft_count2", 32'(bus.count),    32'd2);
    bus.rdreq = 1'b1; sb_q.push_back(8'hB1);
    step();
    sb_q.push_back(8'hB2);
    step();
    chk("fwft_drain_empty", 32'(bus.rd_empty), 32'd1);
    step();
    bus.rdreq = 1'b0;
    chk("fwft_underflow", 32'(bus.underflow), 32'd1);
`else
    // Fill to full.
    for (int i = 0; i < 16; i++) begin
      bus.wrreq = 1'b1; bus.data_in = 8'(i);
      step();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
    end
    bus.wrreq = 1'b0;
    chk("full_flag", 32'(bus.wr_full), 32'd1);
    bus.wrreq = 1'b1; bus.data_in = 8'hFF;
    step();
    bus.wrreq = 1'b0;
    chk("ovf_set",    32'(bus.overflow), 32'd1);
    chk("ovf_count",  32'(bus.count),    32'd16);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      bus.rdreq = 1'b1; sb_q.push_back(8'(i));
      step();
    end
    bus.rdreq = 1'b0;
    chk("drain_empty", 32'(bus.rd_empty), 32'd1);
    chk("drain_count", 32'(bus.count),    32'd0);
    bus.rdreq = 1'b1;
    step();
    bus.rdreq = 1'b0;
    chk("unf_set",      32'(bus.underflow), 32'd1);
    chk("unf_no_valid", 32'(bus.rd_valid),  32'd0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("unf_clr", 32'(bus.underflow), 32'd0);

    // Wrap-around with simultaneous traffic.
    for (int i = 0; i < 10; i++) begin
      bus.wrreq = 1'b1; bus.data_in = 8'(32'h20 + i);
      step();
    end
    bus.wrreq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.rdreq = 1'b1; sb_q.push_back(8'(32'h20 + i));
      step();
    end
    bus.rdreq = 1'b0;
    bus.wrreq = 1'b1; bus.data_in = 8'h40;
    step();
    for (int i = 0; i < 12; i++) begin
      bus.wrreq = 1'b1; bus.data_in = 8'(32'h41 + i);
      bus.rdreq = 1'b1; sb_q.push_back(8'(32'h40 + i));
      step();
      chk("wrap_count", 32'(bus.count), 32'd1);
    end
    bus.wrreq = 1'b0;
    sb_q.push_back(8'h4C);
    step();
    bus.rdreq = 1'b0;
    chk("wrap_final_count", 32'(bus.count), 32'd0);
    step();

    // Threshold flags across a full fill.
    for (int i = 0; i < 16; i++) begin
      bus.wrreq = 1'b1; bus.data_in = 8'(32'h60 + i);
      step();
      chk("thr_aempty", 32'(bus.almost_empty), 32'((i + 1) <= 3));
      chk("thr_afull",  32'(bus.almost_full),  32'((i + 1) >= 12));
    end
    bus.wrreq = 1'b0;
    bus.afull_thresh = 5'd17;  #1;
    chk("thr_afull_17", 32'(bus.almost_full), 32'd0);
    bus.aempty_thresh = 5'd16; #1;
    chk("thr_aempty_16", 32'(bus.almost_empty), 32'd1);
    bus.afull_thresh = 5'd0;   #1;
    chk("thr_afull_0", 32'(bus.almost_full), 32'd1);
    bus.aempty_thresh = 5'd0;  #1;
    chk("thr_aempty_0", 32'(bus.almost_empty), 32'd0);
    bus.afull_thresh  = 5'd12;
    bus.aempty_thresh = 5'd3;
    bus.wrreq = 1'b1;
    step();
    bus.wrreq = 1'b0;
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);

    // Reset in the middle of a read at count 9.
    for (int i = 0; i < 7; i++) begin
      bus.rdreq = 1'b1; sb_q.push_back(8'(32'h60 + i));
      step();
    end
    chk("pre_rst_count", 32'(bus.count), 32'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.rdreq = 1'b0;
    chk("mid_rst_count",    32'(bus.count),    32'd0);
    chk("mid_rst_empty",    32'(bus.rd_empty), 32'd1);
    chk("mid_rst_valid",    32'(bus.rd_valid), 32'd0);
    chk("mid_rst_data",     32'(bus.data_out), 32'd0);
    chk("mid_rst_ovf",      32'(bus.overflow), 32'd0);
    chk("mid_rst_aempty",   32'(bus.almost_empty), 32'd1);
    chk("mid_rst_afull",    32'(bus.almost_full),  32'd0);
    step();
`endif
    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
